// File: rtl/button_reader_pkg.sv
// -----------------------------------------------------------------------------
// button_reader_pkg
//
// Shared definitions for the push-button reader:
//   - per-button FSM state encoding (3 bits, fixed values)
//   - widths of the per-button stable and hold counters
//   - the registered output bundle of one button
//   - a helper mapping an FSM state to the debounced level it represents
// -----------------------------------------------------------------------------
package button_reader_pkg;

    localparam int STABLE_W = 4;   // stable counter width (debounce ticks)
    localparam int HOLD_W   = 8;   // hold counter width (repeat ticks)

    typedef enum logic [2:0] {
        ST_RELEASED  = 3'd0,
        ST_ARMING    = 3'd1,
        ST_PRESSED   = 3'd2,
        ST_REPEATING = 3'd3,
        ST_DISARMING = 3'd4
    } btn_state_t;

    // Registered outputs of one button, all updated on the same edge.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic rpt;
    } btn_out_t;

    // The debounced level is 1 in every state that follows an accepted press
    // and precedes an accepted release (DISARMING still counts as held).
    function automatic logic holds_level(btn_state_t s);
        return (s == ST_PRESSED) || (s == ST_REPEATING) || (s == ST_DISARMING);
    endfunction

endpackage

// File: rtl/button_reader_fsm.sv
// -----------------------------------------------------------------------------
// button_fsm
//
// One push-button channel: 2-flop synchronizer, debounce / auto-repeat FSM,
// the 4-bit stable counter, the 8-bit hold counter and the registered outputs.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset; clears every flop
//   tick   in   one-cycle slow timing strobe shared by all buttons
//   raw    in   raw, bouncy, asynchronous button pin (active-high)
//   level  out  debounced level, 1 = held
//   press  out  one-cycle pulse on an accepted press
//   rel    out  one-cycle pulse on an accepted release
//   rpt    out  one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_fsm
    import button_reader_pkg::*;
#(
    parameter int STABLE_TICKS = 2,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    // Compare limits, zero-extended to the counter widths.
    localparam logic [STABLE_W-1:0] STABLE_LIMIT = STABLE_W'(STABLE_TICKS);
    localparam logic [HOLD_W-1:0]   DELAY_LIMIT  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0]   RATE_LIMIT   = HOLD_W'(REPEAT_RATE);

    logic                sync_meta;
    logic                sync_in;
    btn_state_t          state;
    btn_state_t          state_nxt;
    logic [STABLE_W-1:0] stable_cnt;
    logic [STABLE_W-1:0] stable_nxt;
    logic [STABLE_W-1:0] stable_inc;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [HOLD_W-1:0]   hold_inc;
    btn_out_t            out_q;
    btn_out_t            out_nxt;

    // -------------------------------------------------------------------------
    // Synchronizer: raw is asynchronous to clk, so it gets two flops before
    // anything else looks at it.
    // -------------------------------------------------------------------------
    // NOTE: flops are always written with non-blocking assignments so every
    // register in the design samples the values present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_in   <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_in   <= sync_meta;
        end
    end

    assign stable_inc = stable_cnt + STABLE_W'(1);
    assign hold_inc   = hold_cnt + HOLD_W'(1);

    // -------------------------------------------------------------------------
    // State register: FSM state, both counters and the registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RELEASED;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            out_q      <= '0;
        end else begin
            state      <= state_nxt;
            stable_cnt <= stable_nxt;
            hold_cnt   <= hold_nxt;
            out_q      <= out_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. A change of the synchronized input always takes
    // priority over a coincident tick, so that tick is not counted.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_cnt;
        hold_nxt   = hold_cnt;

        case (state)
            ST_RELEASED: begin
                if (sync_in) begin
                    state_nxt  = ST_ARMING;
                    stable_nxt = '0;
                end
            end

            ST_ARMING: begin
                if (!sync_in) begin
                    state_nxt = ST_RELEASED;
                end else if (tick) begin
                    stable_nxt = stable_inc;
                    if (stable_inc == STABLE_LIMIT) begin
                        state_nxt = ST_PRESSED;
                        hold_nxt  = '0;
                    end
                end
            end

            ST_PRESSED: begin
                if (!sync_in) begin
                    state_nxt  = ST_DISARMING;
                    stable_nxt = '0;
                end else if (tick) begin
                    if (hold_inc == DELAY_LIMIT) begin
                        state_nxt = ST_REPEATING;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_inc;
                    end
                end
            end

            ST_REPEATING: begin
                if (!sync_in) begin
                    state_nxt  = ST_DISARMING;
                    stable_nxt = '0;
                end else if (tick) begin
                    // Each completed period restarts the count in place.
                    hold_nxt = (hold_inc == RATE_LIMIT) ? '0 : hold_inc;
                end
            end

            ST_DISARMING: begin
                if (sync_in) begin
                    // Short release glitch: back to held, repeat delay restarts,
                    // and no second press is reported.
                    state_nxt = ST_PRESSED;
                    hold_nxt  = '0;
                end else if (tick) begin
                    stable_nxt = stable_inc;
                    if (stable_inc == STABLE_LIMIT) begin
                        state_nxt = ST_RELEASED;
                    end
                end
            end

            default: begin
                state_nxt  = ST_RELEASED;
                stable_nxt = '0;
                hold_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: D inputs of the output registers, so each pulse appears on
    // the same edge that takes the FSM through the matching transition.
    // -------------------------------------------------------------------------
    always_comb begin
        out_nxt       = '0;
        out_nxt.level = holds_level(state_nxt);
        out_nxt.press = (state == ST_ARMING) && (state_nxt == ST_PRESSED);
        out_nxt.rel   = (state == ST_DISARMING) && (state_nxt == ST_RELEASED);
        out_nxt.rpt   = ((state == ST_PRESSED) && (state_nxt == ST_REPEATING)) ||
                        ((state == ST_REPEATING) && sync_in && tick &&
                         (hold_inc == RATE_LIMIT));
    end

    assign level = out_q.level;
    assign press = out_q.press;
    assign rel   = out_q.rel;
    assign rpt   = out_q.rpt;

endmodule

// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//
// Reads NUM_BTNS raw push-buttons and produces clean debounced levels plus
// one-cycle press, release and auto-repeat pulses per button. A single shared
// prescaler generates the slow tick used for all debounce and repeat timing.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   btn_in       in   [NUM_BTNS] raw button pins, active-high, async to clk
//   btn_level    out  [NUM_BTNS] debounced state, 1 = held
//   btn_press    out  [NUM_BTNS] one-cycle pulse on an accepted press
//   btn_release  out  [NUM_BTNS] one-cycle pulse on an accepted release
//   btn_repeat   out  [NUM_BTNS] one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_reader
    import button_reader_pkg::*;
#(
    parameter int NUM_BTNS     = 4,
    parameter int TICK_BITS    = 20,
    parameter int STABLE_TICKS = 2,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_repeat
);

    logic [TICK_BITS-1:0] prescaler;
    logic                 tick;

    // Free-running prescaler; wraps naturally every 2^TICK_BITS cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + TICK_BITS'(1);
        end
    end

    // One-cycle strobe while the prescaler is all-ones; the first one after
    // reset therefore lands in cycle 2^TICK_BITS-1.
    assign tick = &prescaler;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_fsm #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_fsm (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (btn_in[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i]),
            .rpt   (btn_repeat[i])
        );
    end

endmodule
